// File: rtl/mult_seq16.sv
// Sequential 16x16 unsigned shift-add multiplier: one cla16 add per iteration,
// 16 iterations per operation, start/busy/done handshake.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] is the carry into bit i
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign sum = p ^ c;
  assign pg  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] sum,
  output logic        c15,
  output logic        c16
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  logic [NUM_LANES-1:0][VEC_W-1:0] a_l, b_l, s_l, c_l;
  logic [NUM_LANES-1:0]            pg, gg;
  logic [NUM_LANES:0]              gc;

  assign a_l = a;
  assign b_l = b;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_blk
      cla4 u_cla4 (
        .a   (a_l[i]),
        .b   (b_l[i]),
        .ci  (gc[i]),
        .sum (s_l[i]),
        .c   (c_l[i]),
        .pg  (pg[i]),
        .gg  (gg[i])
      );
    end
  endgenerate

  // Second-level lookahead across the four 4-bit groups
  assign gc[0] = c0;
  assign gc[1] = gg[0] | (pg[0] & c0);
  assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c0);
  assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & c0);
  assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & c0);

  assign sum = s_l;
  assign c15 = c_l[3][3];
  assign c16 = gc[4];
endmodule

module mult_seq16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [15:0] mc, mc_nxt;
  logic [15:0] hi, hi_nxt;
  logic [15:0] lo, lo_nxt;
  logic        done_r, done_nxt;

  logic [15:0] add_b, add_sum;
  logic        add_c16, c15_unused;

  assign add_b = lo[0] ? mc : 16'h0000;

  cla16 u_cla16 (
    .a   (hi),
    .b   (add_b),
    .c0  (1'b0),
    .sum (add_sum),
    .c15 (c15_unused),
    .c16 (add_c16)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      mc     <= 16'h0000;
      hi     <= 16'h0000;
      lo     <= 16'h0000;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mc     <= mc_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_nxt    = mc;
    hi_nxt    = hi;
    lo_nxt    = lo;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mc_nxt    = mcand;
          hi_nxt    = 16'h0000;
          lo_nxt    = mplier;
          cnt_nxt   = 5'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Add-then-shift: adder carry lands in product bit 31
        {hi_nxt, lo_nxt} = {add_c16, add_sum, lo[15:1]};
        cnt_nxt          = cnt + 5'd1;
        if (cnt == 5'd15) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign done    = done_r;
  assign product = {hi, lo};
endmodule

// File: tb/tb_mult_seq16.sv
// Directed bench for mult_seq16: vector table, handshake corner sequences,
// async reset mid-operation and a short random sweep against a multiply model.

module tb_mult_seq16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mcand = 16'h0;
  logic [15:0] mplier = 16'h0;
  logic        busy, done;
  logic [31:0] product;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult_seq16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done after an accepting edge; returns cycles counted and overlap flag
  task automatic wait_done(output int n, output logic both);
    both = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy && done) both = 1'b1;
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    int n;
    logic both;
    start = 1'b1; mcand = a; mplier = b;
    tick();
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    chk({name, " busy@E0"}, {31'd0, busy}, 32'd1);
    wait_done(n, both);
    chk({name, " latency"}, n, 32'd16);
    chk({name, " product"}, product, exp);
    chk({name, " busy&done"}, {31'd0, both}, 32'd0);
    tick();
    chk({name, " done width"}, {31'd0, done}, 32'd0);
    chk({name, " hold"}, product, exp);
  endtask

  initial begin
    vec_t vt[13];
    int n;
    logic both;
    int pulses;
    logic [15:0] corners[4];

    vt[0]  = '{16'd3,    16'd5,    32'h0000000F};
    vt[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vt[2]  = '{16'h8000, 16'd2,    32'h00010000};
    vt[3]  = '{16'h0000, 16'hFFFF, 32'h00000000};
    vt[4]  = '{16'hFFFF, 16'h0000, 32'h00000000};
    vt[5]  = '{16'd1,    16'd1,    32'h00000001};
    vt[6]  = '{16'd1,    16'hFFFF, 32'h0000FFFF};
    vt[7]  = '{16'hFFFF, 16'd1,    32'h0000FFFF};
    vt[8]  = '{16'd100,  16'd200,  32'h00004E20};
    vt[9]  = '{16'd1234, 16'd5678, 32'h006AE9BC};
    vt[10] = '{16'h8000, 16'h8000, 32'h40000000};
    vt[11] = '{16'hABCD, 16'h0010, 32'h000ABCD0};
    vt[12] = '{16'h00FF, 16'h0101, 32'h0000FFFF};

    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("idle product", product, 32'd0);

    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p);

    // start during RUN must be ignored
    start = 1'b1; mcand = 16'd100; mplier = 16'd200;
    tick();
    start = 1'b0;
    pulses = 0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin start = 1'b1; mcand = 16'd7; mplier = 16'd9; end
      else start = 1'b0;
      tick();
      if (done) begin
        pulses++;
        if (n == 0) begin
          n = k;
          chk("ignored product", product, 32'h00004E20);
        end
      end
    end
    start = 1'b0;
    chk("ignored latency", n, 32'd16);
    chk("ignored pulses", pulses, 32'd1);
    chk("ignored idle", {31'd0, busy}, 32'd0);

    // back-to-back: new start in the done cycle
    start = 1'b1; mcand = 16'd3; mplier = 16'd5;
    tick();
    start = 1'b0;
    wait_done(n, both);
    chk("b2b first latency", n, 32'd16);
    chk("b2b first product", product, 32'h0000000F);
    start = 1'b1; mcand = 16'd12; mplier = 16'd0;
    tick();
    start = 1'b0;
    chk("b2b busy", {31'd0, busy}, 32'd1);
    chk("b2b done low", {31'd0, done}, 32'd0);
    chk("b2b overwrite", product, 32'd0);
    wait_done(n, both);
    chk("b2b second latency", n, 32'd16);
    chk("b2b second product", product, 32'd0);
    tick();

    // async reset at iteration 8
    start = 1'b1; mcand = 16'd1234; mplier = 16'd5678;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst product", product, 32'd0);
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post-rst idle", {31'd0, busy}, 32'd0);
    run_op("post-rst", 16'd2, 16'd3, 32'h00000006);

    // random sweep with corner operands and idle gaps
    corners[0] = 16'h0000; corners[1] = 16'h0001;
    corners[2] = 16'hFFFF; corners[3] = 16'h8000;
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, 32'(a) * 32'(b));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
